// File: rtl/sma_ctrl_pkg.sv
// sma_ctrl_pkg: shared types and helpers for the moving-average sequencing
// controller (sma_window_ctrl and its latency pipe).
package sma_ctrl_pkg;

  // Largest window select the core supports (N = 2^13 = 8192).
  localparam int unsigned SMA_MAX_SEL = 13;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } sma_state_e;

  // Unsigned clamp of a requested window select to the supported maximum.
  function automatic logic [31:0] clamp_sel(input logic [31:0] req,
                                            input logic [31:0] max_sel);
    return (req > max_sel) ? max_sel : req;
  endfunction

endpackage

// File: rtl/sma_window_ctrl_if.sv
// sma_window_ctrl_if: sample path, window request, core-side signals and
// averaged result of the moving-average sequencing controller.
// slave  = controller side, master = upstream/core/downstream side.
interface sma_window_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_data_vld;
  logic [DATA_W-1:0] i_data;
  logic [31:0]       i_window_req;
  logic              o_sma_strobe;
  logic [DATA_W-1:0] o_sma_data;
  logic [31:0]       o_sma_window_sel;
  logic              o_sma_clr;
  logic [DATA_W-1:0] i_sma_data;
  logic [DATA_W-1:0] o_data;
  logic              o_data_vld;
  logic              o_settling;
  logic [15:0]       o_drop_cnt;

  modport slave (
    input  i_data_vld, i_data, i_window_req, i_sma_data,
    output o_sma_strobe, o_sma_data, o_sma_window_sel, o_sma_clr,
           o_data, o_data_vld, o_settling, o_drop_cnt
  );

  modport master (
    output i_data_vld, i_data, i_window_req, i_sma_data,
    input  o_sma_strobe, o_sma_data, o_sma_window_sel, o_sma_clr,
           o_data, o_data_vld, o_settling, o_drop_cnt
  );
endinterface

// File: rtl/sma_ctrl_lat_pipe.sv
// sma_ctrl_lat_pipe: SMA_LAT-deep shift register of "this strobe completes a
// full window" tags. The last stage becomes the capture enable for the
// averaged output register. A kill wipes every stage (including the tag
// arriving in the same cycle) so results of an abandoned window never
// surface, and also masks a capture that would otherwise happen that cycle.
module sma_ctrl_lat_pipe #(
  parameter int unsigned SMA_LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_kill,
  input  logic i_tag,
  output logic o_cap_en
);

  logic [SMA_LAT-1:0] tag_q;

  // Tag shift register with synchronous reset and kill.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_kill) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= i_tag;
      for (int i = 1; i < int'(SMA_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign o_cap_en = tag_q[SMA_LAT-1] & ~i_kill;

endmodule

// File: rtl/sma_window_ctrl.sv
// sma_window_ctrl: sequencing controller for the moving-average core.
// Registers samples into the core, issues its update strobe, applies window
// changes only after flushing the core, and flags outputs that cover a full
// window of the active size.
// Optional feature: define SMA_CTRL_DROP_CNT_EN to build the saturating
// counter of samples dropped during FLUSH (otherwise o_drop_cnt is 0).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FLUSH | core held in clear for FLUSH_CYCLES, samples dropped
// ST_FILL  | strobing samples until 2^active_sel have entered the core
// ST_RUN   | full window present, every strobe yields a valid average
module sma_window_ctrl
  import sma_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_SEL      = SMA_MAX_SEL,
  parameter int unsigned DEFAULT_SEL  = 2,
  parameter int unsigned SMA_LAT      = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sma_window_ctrl_if.slave bus
);

  localparam int unsigned     FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LD = FC_W'(FLUSH_CYCLES - 1);
  localparam int unsigned     FILL_W   = MAX_SEL + 1;

  sma_state_e        state, state_nxt;
  logic [31:0]       active_sel, sel_nxt, req_c;
  logic [FC_W-1:0]   flush_cnt, flush_nxt;
  logic [FILL_W-1:0] fill_cnt, fill_nxt, fill_inc, fill_target;
  logic              change, strobe_c, tag_c, kill, cap_en;

  logic              strobe_q, clr_q, settling_q, data_vld_q;
  logic [DATA_W-1:0] sma_data_q, data_q;

  assign req_c       = clamp_sel(bus.i_window_req, MAX_SEL);
  assign change      = (req_c != active_sel);
  assign fill_target = FILL_W'(1) << active_sel;
  assign fill_inc    = fill_cnt + FILL_W'(1);

  // Pipe is cleared on the cycle the FSM commits to FLUSH.
  assign kill = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);

  // State, active select, flush timer and fill count registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_FLUSH;
      active_sel <= DEFAULT_SEL;
      flush_cnt  <= FLUSH_LD;
      fill_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      active_sel <= sel_nxt;
      flush_cnt  <= flush_nxt;
      fill_cnt   <= fill_nxt;
    end
  end

  // Next-state, strobe and tag decisions.
  always_comb begin
    state_nxt = state;
    sel_nxt   = active_sel;
    flush_nxt = flush_cnt;
    fill_nxt  = fill_cnt;
    strobe_c  = 1'b0;
    tag_c     = 1'b0;
    case (state)
      ST_FLUSH: begin
        if (change) begin
          sel_nxt   = req_c;
          flush_nxt = FLUSH_LD;
        end else if (flush_cnt == '0) begin
          state_nxt = ST_FILL;
          fill_nxt  = '0;
        end else begin
          flush_nxt = flush_cnt - FC_W'(1);
        end
      end
      ST_FILL: begin
        if (bus.i_data_vld) begin
          strobe_c = 1'b1;
          fill_nxt = fill_inc;
          if (fill_inc == fill_target) begin
            tag_c     = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        // A sample arriving with the change is still strobed; its tag dies
        // with the pipe kill.
        if (change) begin
          state_nxt = ST_FLUSH;
          sel_nxt   = req_c;
          flush_nxt = FLUSH_LD;
        end
      end
      ST_RUN: begin
        if (bus.i_data_vld) begin
          strobe_c = 1'b1;
          tag_c    = 1'b1;
        end
        if (change) begin
          state_nxt = ST_FLUSH;
          sel_nxt   = req_c;
          flush_nxt = FLUSH_LD;
        end
      end
      default: begin
        state_nxt = ST_FLUSH;
        flush_nxt = FLUSH_LD;
      end
    endcase
  end

  // Registered core-side outputs and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      strobe_q   <= 1'b0;
      sma_data_q <= '0;
      clr_q      <= 1'b1;
      settling_q <= 1'b1;
    end else begin
      strobe_q   <= strobe_c;
      if (strobe_c) begin
        sma_data_q <= bus.i_data;
      end
      clr_q      <= (state_nxt == ST_FLUSH);
      settling_q <= (state_nxt != ST_RUN);
    end
  end

  sma_ctrl_lat_pipe #(
    .SMA_LAT (SMA_LAT)
  ) u_lat_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_kill   (kill),
    .i_tag    (tag_c),
    .o_cap_en (cap_en)
  );

  // Full-window result register: the core output presented in the cycle
  // before capture lands here SMA_LAT cycles after its strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q     <= '0;
      data_vld_q <= 1'b0;
    end else begin
      data_vld_q <= cap_en;
      if (cap_en) begin
        data_q <= bus.i_sma_data;
      end
    end
  end

`ifdef SMA_CTRL_DROP_CNT_EN
  logic        drop_c;
  logic [15:0] drop_cnt;

  assign drop_c = bus.i_data_vld && (state == ST_FLUSH);

  // Saturating count of samples discarded while the core is flushed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt <= '0;
    end else if (drop_c && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.o_drop_cnt = drop_cnt;
`else
  assign bus.o_drop_cnt = '0;
`endif

  assign bus.o_sma_strobe     = strobe_q;
  assign bus.o_sma_data       = sma_data_q;
  assign bus.o_sma_window_sel = active_sel;
  assign bus.o_sma_clr        = clr_q;
  assign bus.o_data           = data_q;
  assign bus.o_data_vld       = data_vld_q;
  assign bus.o_settling       = settling_q;

endmodule

// File: tb/tb_sma_window_ctrl.sv
// tb_sma_window_ctrl: directed stimulus with a scoreboard of expected
// full-window results; a negedge monitor pops and compares each o_data_vld.
module tb_sma_window_ctrl;

  localparam int SMA_LAT = 2;
`ifdef SMA_CTRL_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic  clk;
  logic  rst;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  q[$];
  logic [31:0] core_q;

  sma_window_ctrl_if #(.DATA_W(32)) bus ();

  sma_window_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: returns the most recently strobed sample.
  always @(posedge clk) begin
    if (rst) core_q <= '0;
    else if (bus.o_sma_strobe) core_q <= bus.o_sma_data;
  end
  assign bus.i_sma_data = core_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_vld: no o_data_vld at cycle %0d for data %0d", e.cyc, e.d);
    end
    if (bus.o_data_vld) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_vld: o_data %0d at cycle %0d, none expected", bus.o_data, cyc);
      end else begin
        e = q.pop_front();
        check("o_data", bus.o_data, e.d);
        check("vld_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Back-to-back samples base..base+n-1; those with index >= tag_from expect a result.
  task automatic burst(input int n, input logic [31:0] base, input int tag_from);
    for (int i = 0; i < n; i++) begin
      bus.i_data_vld = 1'b1;
      bus.i_data     = base + 32'(i);
      if (i >= tag_from) q.push_back('{d: base + 32'(i), cyc: cyc + 1 + SMA_LAT});
      step();
    end
    bus.i_data_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.i_data_vld   = 1'b0;
    bus.i_data       = '0;
    bus.i_window_req = 32'd2;

    // Reset values, then FILL at sel 2 with sparse pulses of 100.
    idle(3);
    check("rst_sel", bus.o_sma_window_sel, 2);
    check("rst_clr", bus.o_sma_clr, 1);
    check("rst_settling", bus.o_settling, 1);
    check("rst_strobe", bus.o_sma_strobe, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_vld", bus.o_data_vld, 0);
    check("rst_drop", bus.o_drop_cnt, 0);
    rst = 1'b0;
    check("clr_c0", bus.o_sma_clr, 1);
    step();
    check("clr_c1", bus.o_sma_clr, 1);
    step();
    check("clr_c2", bus.o_sma_clr, 0);
    for (int i = 0; i < 4; i++) begin
      bus.i_data_vld = 1'b1;
      bus.i_data     = 32'd100;
      if (i == 3) q.push_back('{d: 32'd100, cyc: cyc + 1 + SMA_LAT});
      step();
      bus.i_data_vld = 1'b0;
      check("fill_strobe", bus.o_sma_strobe, 1);
      check("fill_sma_data", bus.o_sma_data, 100);
      check("fill_settling", bus.o_settling, (i == 3) ? 0 : 1);
      idle(89);
    end

    // RUN at sel 2: every sample yields a result.
    burst(2, 32'd7, 0);
    idle(5);

    // Window change in RUN to sel 3.
    bus.i_window_req = 32'd3;
    step();
    check("chg_sel", bus.o_sma_window_sel, 3);
    check("chg_clr0", bus.o_sma_clr, 1);
    step();
    check("chg_clr1", bus.o_sma_clr, 1);
    step();
    check("chg_clr2", bus.o_sma_clr, 0);
    check("chg_settling", bus.o_settling, 1);
    burst(8, 32'd200, 7);
    idle(6);

    // Sample and change together, then three samples dropped in FLUSH.
    bus.i_data_vld   = 1'b1;
    bus.i_data       = 32'd55;
    bus.i_window_req = 32'd2;
    step();
    check("sim_strobe", bus.o_sma_strobe, 1);
    check("sim_sma_data", bus.o_sma_data, 55);
    check("sim_clr", bus.o_sma_clr, 1);
    check("sim_sel", bus.o_sma_window_sel, 2);
    bus.i_data       = 32'd60;
    bus.i_window_req = 32'd3;
    step();
    check("drop_sel", bus.o_sma_window_sel, 3);
    check("drop_strobe", bus.o_sma_strobe, 0);
    bus.i_data = 32'd61;
    step();
    bus.i_data = 32'd62;
    step();
    bus.i_data_vld = 1'b0;
    check("drop_cnt", bus.o_drop_cnt, EXP_DROP);
    check("drop_clr_off", bus.o_sma_clr, 0);

    // Reset mid-FILL after 2 of 8 samples.
    burst(2, 32'd300, 2);
    rst              = 1'b1;
    bus.i_window_req = 32'd2;
    idle(2);
    rst = 1'b0;
    check("mrst_sel", bus.o_sma_window_sel, 2);
    check("mrst_data", bus.o_data, 0);
    check("mrst_clr", bus.o_sma_clr, 1);
    check("mrst_drop", bus.o_drop_cnt, 0);
    idle(2);
    burst(4, 32'd400, 3);
    idle(6);

    // Reset right after a tagged RUN strobe: its result must never appear.
    bus.i_data_vld = 1'b1;
    bus.i_data     = 32'd77;
    step();
    bus.i_data_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    check("kill_data", bus.o_data, 0);

    // Clamp: request 20 selects 13, fill needs 8192 samples.
    bus.i_window_req = 32'd20;
    step();
    check("clamp_sel", bus.o_sma_window_sel, 13);
    check("clamp_clr", bus.o_sma_clr, 1);
    idle(2);
    burst(8191, 32'd1000, 8191);
    check("clamp_settling_pre", bus.o_settling, 1);
    burst(1, 32'd9191, 0);
    check("clamp_settling_post", bus.o_settling, 0);
    idle(8);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
